// File: rtl/deadtime_l1.sv
// rtl/deadtime_l1.sv - complementary gate command generator with break-before-make dead time
// Optional fault latch: define DT_FAULT_LATCH_EN to add fault_in/fault_clr/fault and the FAULT state.
module deadtime_l1 #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   resetn,
  input  logic                   ce,
  input  logic                   enable,
  input  logic                   pwm_in,
  input  logic [COUNT_WIDTH-1:0] deadtime,
`ifdef DT_FAULT_LATCH_EN
  input  logic                   fault_in,
  input  logic                   fault_clr,
  output logic                   fault,
`endif
  output logic                   s_hi,
  output logic                   s_lo,
  output logic [2:0]             state
);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DT_HI = 3'd1,
    ST_HI    = 3'd2,
    ST_DT_LO = 3'd3,
    ST_LO    = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;

  state_t                 cur_state;
  state_t                 nxt_state;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] cnt_nxt;

  assign state = cur_state;

  // Next-state and dead-time counter: enable gates everything, glitches collapse back to the
  // side that was already on, and the counter only moves on ce ticks and stops at zero.
  always_comb begin
    nxt_state = cur_state;
    cnt_nxt   = cnt;
    if (!enable) begin
      nxt_state = ST_OFF;
    end else begin
      case (cur_state)
        ST_OFF: begin
          cnt_nxt   = deadtime;
          nxt_state = pwm_in ? ST_DT_HI : ST_DT_LO;
        end
        ST_LO: begin
          if (pwm_in) begin
            cnt_nxt   = deadtime;
            nxt_state = ST_DT_HI;
          end
        end
        ST_HI: begin
          if (!pwm_in) begin
            cnt_nxt   = deadtime;
            nxt_state = ST_DT_LO;
          end
        end
        ST_DT_HI: begin
          if (!pwm_in) begin
            nxt_state = ST_LO;
          end else if (cnt == CNT_ZERO) begin
            nxt_state = ST_HI;
          end else if (ce) begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        ST_DT_LO: begin
          if (pwm_in) begin
            nxt_state = ST_HI;
          end else if (cnt == CNT_ZERO) begin
            nxt_state = ST_LO;
          end else if (ce) begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        default: begin
          nxt_state = ST_OFF;
        end
      endcase
    end
`ifdef DT_FAULT_LATCH_EN
    // The fault latch overrides everything above: a fault wins over enable and pwm_in,
    // and once latched only a clear with the fault source gone releases it.
    if (fault_in) begin
      nxt_state = ST_FAULT;
    end else if (cur_state == ST_FAULT) begin
      nxt_state = fault_clr ? ST_OFF : ST_FAULT;
    end
`endif
  end

  // State, counter and gate commands; outputs decode the next state so they line up with it.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      cur_state <= ST_OFF;
      cnt       <= CNT_ZERO;
      s_hi      <= 1'b0;
      s_lo      <= 1'b0;
`ifdef DT_FAULT_LATCH_EN
      fault     <= 1'b0;
`endif
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_nxt;
      s_hi      <= (nxt_state == ST_HI);
      s_lo      <= (nxt_state == ST_LO);
`ifdef DT_FAULT_LATCH_EN
      fault     <= (nxt_state == ST_FAULT);
`endif
    end
  end

endmodule
